// File: rtl/cas_byte_feeder.sv
// Cassette byte feeder: sends a fixed leader, then streams the tape image from
// memory into the square-wave generator through a one-byte prefetch buffer.
module cas_byte_feeder #(
  parameter int unsigned ADDR_W      = 24,
  parameter logic [15:0] LEADER_LEN  = 16'd160,
  parameter logic [7:0]  LEADER_BYTE = 8'h55,
  parameter int unsigned GUARD       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] file_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic              sg_start,
  output logic [7:0]        sg_byte,
  output logic              sg_extend,
  input  logic              sg_done,
  output logic              busy,
  output logic              eof,
  output logic [ADDR_W-1:0] pos
);

  localparam int unsigned GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADER,
    S_STREAM,
    S_PAUSE,
    S_EOF
  } state_t;

  state_t            state_q, state_d;
  state_t            resume_q, resume_d;
  logic [ADDR_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic              rd_q, rd_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  logic [15:0]       lead_cnt_q, lead_cnt_d;
  logic              inflight_q, inflight_d;
  logic [GW-1:0]     guard_q, guard_d;
  logic              start_q, start_d;
  logic [7:0]        byte_q, byte_d;
  logic              ext_q, ext_d;
  logic              rew_pend_q, rew_pend_d;

  logic gen_idle, ack_ok, rew_now, sending, avail, issue, fetching;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      resume_q   <= S_LEADER;
      size_q     <= '0;
      addr_q     <= '0;
      pos_q      <= '0;
      rd_q       <= 1'b0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      lead_cnt_q <= LEADER_LEN;
      inflight_q <= 1'b0;
      guard_q    <= '0;
      start_q    <= 1'b0;
      byte_q     <= 8'h00;
      ext_q      <= 1'b0;
      rew_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      pos_q      <= pos_d;
      rd_q       <= rd_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      lead_cnt_q <= lead_cnt_d;
      inflight_q <= inflight_d;
      guard_q    <= guard_d;
      start_q    <= start_d;
      byte_q     <= byte_d;
      ext_q      <= ext_d;
      rew_pend_q <= rew_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    size_d     = size_q;
    addr_d     = addr_q;
    pos_d      = pos_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    lead_cnt_d = lead_cnt_q;
    inflight_d = inflight_q;
    guard_d    = (guard_q != '0) ? guard_q - GW'(1) : guard_q;
    start_d    = 1'b0;
    byte_d     = byte_q;
    ext_d      = ext_q;

    ack_ok   = mem_ack && rd_q;
    gen_idle = !inflight_q || ((guard_q == '0) && sg_done);
    // A rewind seen while a read is outstanding waits for that read's ack.
    rew_now    = (rewind || rew_pend_q) && (!rd_q || mem_ack);
    rew_pend_d = (rewind || rew_pend_q) && rd_q && !mem_ack;

    if (inflight_q && (guard_q == '0) && sg_done)
      inflight_d = 1'b0;

    if (ack_ok) begin
      buf_d     = mem_din;
      buf_vld_d = 1'b1;
      addr_d    = addr_q + ADDR_W'(1);
    end

    sending = ((state_q == S_LEADER) || (state_q == S_STREAM)) && play && !rewind && !rew_pend_q;
    avail   = (state_q == S_LEADER) ? (lead_cnt_q != '0) : buf_vld_q;
    issue   = sending && avail && gen_idle;

    if (issue) begin
      start_d    = 1'b1;
      inflight_d = 1'b1;
      guard_d    = GW'(GUARD);
      if (state_q == S_LEADER) begin
        byte_d     = LEADER_BYTE;
        ext_d      = 1'b0;
        lead_cnt_d = lead_cnt_q - 16'd1;
      end else begin
        byte_d    = buf_q;
        ext_d     = 1'b1;
        buf_vld_d = 1'b0;
        pos_d     = pos_q + ADDR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (play) begin
          size_d = file_size;
          if (file_size == '0)
            state_d = S_EOF;
          else
            state_d = (LEADER_LEN == 16'd0) ? S_STREAM : S_LEADER;
        end
      end
      S_LEADER: begin
        if (!play) begin
          state_d  = S_PAUSE;
          resume_d = S_LEADER;
        end else if (issue && (lead_cnt_d == 16'd0)) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if ((pos_q == size_q) && gen_idle) begin
          state_d = S_EOF;
        end else if (!play) begin
          state_d  = S_PAUSE;
          resume_d = S_STREAM;
        end
      end
      S_PAUSE: begin
        if (play)
          state_d = resume_q;
      end
      S_EOF: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Rewind discards any just-acked data; the in-flight byte is left to finish.
    if (rew_now) begin
      state_d    = S_IDLE;
      addr_d     = '0;
      pos_d      = '0;
      buf_vld_d  = 1'b0;
      lead_cnt_d = LEADER_LEN;
    end

    fetching = (state_d == S_LEADER) || (state_d == S_STREAM) || (state_d == S_PAUSE);
    rd_d     = (rd_q && !mem_ack) ||
               (!rew_now && fetching && !buf_vld_d && (addr_d < size_d));
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign sg_start  = start_q;
  assign sg_byte   = byte_q;
  assign sg_extend = ext_q;
  assign pos       = pos_q;
  assign eof       = (state_q == S_EOF);
  assign busy      = (state_q == S_LEADER) || (state_q == S_STREAM) || (state_q == S_PAUSE) ||
                     (inflight_q && (state_q != S_EOF));

endmodule

// File: tb/tb_cas_byte_feeder.sv
// Bench for cas_byte_feeder: random images served by a memory model, a timed
// generator model, and an expected strobe list built from leader + image bytes.
module tb_cas_byte_feeder;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned LLEN   = 3;
  localparam int unsigned GEN_T  = 20;

  logic              clk = 1'b0;
  logic              reset, play, rewind;
  logic [ADDR_W-1:0] file_size, mem_addr, pos;
  logic              mem_rd, mem_ack, sg_start, sg_extend, sg_done, busy, eof;
  logic [7:0]        mem_din, sg_byte;

  cas_byte_feeder #(
    .ADDR_W     (ADDR_W),
    .LEADER_LEN (16'(LLEN)),
    .LEADER_BYTE(8'h55),
    .GUARD      (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .rewind   (rewind),
    .file_size(file_size),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_din  (mem_din),
    .mem_ack  (mem_ack),
    .sg_start (sg_start),
    .sg_byte  (sg_byte),
    .sg_extend(sg_extend),
    .sg_done  (sg_done),
    .busy     (busy),
    .eof      (eof),
    .pos      (pos)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_errors = 0;
  logic [7:0]  img [0:255];
  logic [8:0]  exp_q [$];
  int unsigned cyc = 0, n_strobes = 0, n_img = 0, n_reqs = 0, last_strobe_cyc = 0;
  int unsigned extra_strobes = 0, overlaps = 0, rd_drops = 0;
  int unsigned lat_min = 2, lat_jit = 2;
  int unsigned gen_cnt = 0, mem_cnt = 0;
  bit          mem_busy = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Generator and memory models; also scores every strobe against exp_q.
  initial begin
    mem_ack = 1'b0;
    mem_din = 8'h00;
    sg_done = 1'bx;
    forever begin
      @(negedge clk);
      cyc++;
      if (sg_start) begin
        n_strobes++;
        if (sg_extend) n_img++;
        last_strobe_cyc = cyc;
        if (gen_cnt != 0) overlaps++;
        if (exp_q.size() == 0) extra_strobes++;
        else check_eq("strobe", {23'd0, sg_extend, sg_byte}, {23'd0, exp_q.pop_front()});
        gen_cnt = GEN_T;
        sg_done = 1'b0;
      end else if (gen_cnt != 0) begin
        gen_cnt--;
        if (gen_cnt == 0) sg_done = 1'b1;
      end
      if (reset) begin
        mem_ack  = 1'b0;
        mem_busy = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_busy) begin
        if (!mem_rd) begin
          rd_drops++;
          mem_busy = 1'b0;
        end else if (mem_cnt <= 1) begin
          mem_ack  = 1'b1;
          mem_din  = img[req_addr[7:0]];
          mem_busy = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else if (mem_rd) begin
        mem_busy = 1'b1;
        n_reqs++;
        req_addr = mem_addr;
        mem_cnt  = lat_min + $urandom_range(0, lat_jit);
      end
    end
  end

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load_image(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) img[i] = 8'($urandom);
    file_size = ADDR_W'(n);
  endtask

  task automatic expect_stream(input int unsigned n);
    for (int unsigned i = 0; i < LLEN; i++) exp_q.push_back({1'b0, 8'h55});
    for (int unsigned i = 0; i < n; i++) exp_q.push_back({1'b1, img[i]});
  endtask

  task automatic wait_eof(input string tag, input int unsigned budget);
    int unsigned k = 0;
    while (!eof && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 32'(eof), 1);
  endtask

  task automatic wait_img(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned k = 0;
    while (n_img < target && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 32'(n_img >= target), 1);
  endtask

  task automatic wait_rd(input string tag, input logic level, input int unsigned budget);
    int unsigned k = 0;
    while (mem_rd !== level && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 32'(mem_rd), 32'(level));
  endtask

  task automatic pulse_rewind();
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s0, d;
    reset = 1'b1; play = 1'b0; rewind = 1'b0; file_size = '0;
    step(2);
    check_eq("rst_ctrl", 32'({mem_rd, sg_start, busy, eof, sg_extend}), 0);
    check_eq("rst_addr", 32'(mem_addr), 0);
    check_eq("rst_pos", 32'(pos), 0);
    check_eq("rst_byte", 32'(sg_byte), 0);
    reset = 1'b0;
    step(6);
    check_eq("idle_no_strobe", n_strobes, 0);

    // Two-byte image: three leader bytes then A5, 3C.
    img[0] = 8'hA5; img[1] = 8'h3C; file_size = 2;
    expect_stream(2);
    s0 = n_strobes;
    play = 1'b1;
    wait_eof("a_eof", 1000);
    d = cyc - last_strobe_cyc;
    check_eq("a_strobes", n_strobes - s0, 5);
    check_eq("a_eof_delay_ok", 32'(d >= 20 && d <= 23), 1);
    check_eq("a_pos", 32'(pos), 2);
    check_eq("a_busy", 32'(busy), 0);
    check_eq("a_left", 32'(exp_q.size()), 0);
    step(10);
    check_eq("a_eof_hold", 32'(eof), 1);
    check_eq("a_no_more", n_strobes - s0, 5);
    play = 1'b0;
    pulse_rewind();
    check_eq("rew_eof_clear", 32'({eof, pos}), 0);

    // Slow memory: every image strobe waits on the buffer.
    load_image(4);
    lat_min = 30; lat_jit = 0;
    expect_stream(4);
    s0 = n_strobes;
    play = 1'b1;
    wait_eof("b_eof", 3000);
    check_eq("b_strobes", n_strobes - s0, 7);
    check_eq("b_pos", 32'(pos), 4);
    check_eq("b_left", 32'(exp_q.size()), 0);
    play = 1'b0;
    pulse_rewind();

    // Pause after the second image byte, then resume.
    load_image(4);
    lat_min = 2; lat_jit = 3;
    expect_stream(4);
    play = 1'b1;
    wait_img("c_two_img", n_img + 2, 1000);
    play = 1'b0;
    s0 = n_strobes;
    step(60);
    check_eq("c_paused_strobes", n_strobes - s0, 0);
    check_eq("c_pos", 32'(pos), 2);
    check_eq("c_busy", 32'(busy), 1);
    check_eq("c_pending", 32'(exp_q.size()), 2);
    play = 1'b1;
    wait_img("c_resume", n_img + 1, 200);
    wait_eof("c_eof", 1000);
    check_eq("c_pos_end", 32'(pos), 4);
    check_eq("c_left", 32'(exp_q.size()), 0);
    play = 1'b0;
    pulse_rewind();

    // Rewind while a read is outstanding.
    load_image(3);
    lat_min = 30; lat_jit = 0;
    expect_stream(3);
    s0 = n_strobes;
    play = 1'b1;
    wait_img("d_first_img", n_img + 1, 1000);
    wait_rd("d_rd_up", 1'b1, 50);
    rewind = 1'b1;
    exp_q.delete();
    step();
    rewind = 1'b0;
    d = n_strobes;
    check_eq("d_rd_held", 32'(mem_rd), 1);
    check_eq("d_pos_deferred", 32'(pos), 1);
    wait_rd("d_ack", 1'b0, 100);
    check_eq("d_pos_zero", 32'(pos), 0);
    check_eq("d_addr_zero", 32'(mem_addr), 0);
    check_eq("d_no_strobe", n_strobes - d, 0);
    expect_stream(3);
    wait_eof("d_eof", 3000);
    check_eq("d_total", n_strobes - s0, 10);
    check_eq("d_pos_end", 32'(pos), 3);
    check_eq("d_left", 32'(exp_q.size()), 0);
    play = 1'b0;
    pulse_rewind();

    // Empty image goes straight to EOF.
    file_size = '0;
    s0 = n_strobes;
    d = n_reqs;
    play = 1'b1;
    step(2);
    check_eq("e_eof", 32'(eof), 1);
    step(10);
    check_eq("e_no_rd", n_reqs - d, 0);
    check_eq("e_no_strobe", n_strobes - s0, 0);
    check_eq("e_busy", 32'(busy), 0);
    play = 1'b0;
    pulse_rewind();

    // Asynchronous reset in the middle of a leader byte.
    load_image(4);
    lat_min = 2; lat_jit = 3;
    expect_stream(4);
    s0 = n_strobes;
    play = 1'b1;
    while (n_strobes < s0 + 2 && cyc < 100_000) step();
    step(3);
    #2 reset = 1'b1;
    #1;
    check_eq("f_rst_ctrl", 32'({mem_rd, sg_start, busy, eof, sg_extend}), 0);
    check_eq("f_rst_byte", 32'(sg_byte), 0);
    check_eq("f_rst_pos", 32'({mem_addr, pos}), 0);
    play = 1'b0;
    step(2);
    reset = 1'b0;
    exp_q.delete();
    s0 = n_strobes;
    step(30);
    check_eq("f_idle_no_strobe", n_strobes - s0, 0);
    expect_stream(4);
    play = 1'b1;
    wait_eof("f_eof", 1000);
    check_eq("f_pos", 32'(pos), 4);
    check_eq("f_left", 32'(exp_q.size()), 0);

    check_eq("overlaps", overlaps, 0);
    check_eq("extra_strobes", extra_strobes, 0);
    check_eq("rd_drops", rd_drops, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cas_byte_feeder.md
Name: cas_byte_feeder

Overview:
- Upstream stage of the cassette square-wave generator.
- Streams a loaded tape image from memory into the generator, one byte per handshake.
- Prepends a leader of fixed bytes and prefetches the next byte while the current one is being serialized.
- Supplies byte, extend flag and start strobe, and consumes the generator's done level.

Parameters:
- ADDR_W, 24, width of tape image byte address and size.
- LEADER_LEN, 16'd160, number of leader bytes sent before image byte 0.
- LEADER_BYTE, 8'h55, leader byte value; always sent with extend=0.
- GUARD, 2, clk cycles after a start strobe during which sg_done is ignored.

Ports:
- clk, in, 1, system clock (same clock as the square generator).
- reset, in, 1, asynchronous active-high reset.
- play, in, 1, level; 1 = run, 0 = pause after the current byte.
- rewind, in, 1, one-cycle pulse; return to image start with leader re-armed.
- file_size, in, ADDR_W, image length in bytes; sampled when leaving IDLE.
- mem_addr, out, ADDR_W, read address.
- mem_rd, out, 1, read request; held high until mem_ack.
- mem_din, in, 8, read data; valid in the mem_ack cycle.
- mem_ack, in, 1, one-cycle acknowledge.
- sg_start, out, 1, one-cycle start strobe to the generator.
- sg_byte, out, 8, byte to serialize.
- sg_extend, out, 1, 1 = 9-bit framed image byte, 0 = 8-bit leader byte.
- sg_done, in, 1, generator finished level; undefined before the first strobe.
- busy, out, 1, high in LEADER/STREAM/PAUSE, or while a byte is in flight.
- eof, out, 1, last image byte fully serialized.
- pos, out, ADDR_W, index of the next image byte to be sent.

Behaviour:
- Reset (async) values:
  - mem_rd, sg_start, busy, eof = 0; mem_addr, pos = 0; sg_byte = 8'h00; sg_extend = 0.
  - State IDLE; buffer empty; leader counter = LEADER_LEN; in-flight flag = 0.
- States: IDLE, LEADER, STREAM, PAUSE, EOF.
- IDLE:
  - play=1 and file_size!=0 -> LEADER; latch size.
  - play=1 and file_size==0 -> EOF, no leader.
- Issue rule (all states that send):
  - sg_start is asserted the cycle after the generator is idle AND a byte is available AND play=1.
  - Generator idle = in-flight flag clear, OR (guard counter expired AND sg_done=1).
  - sg_byte and sg_extend are registered in the same cycle as sg_start and held until the next strobe.
  - Each strobe sets the in-flight flag and loads the guard counter with GUARD.
- LEADER:
  - Issue LEADER_BYTE with extend=0; decrement the leader counter per strobe.
  - First image fetch (mem_addr=0) starts on entry.
  - Counter reaches 0 -> STREAM.
- STREAM:
  - One-byte prefetch buffer. When the buffer is empty and mem_addr < size, assert mem_rd.
  - On mem_ack: capture mem_din into the buffer; mem_addr += 1.
  - Issue from the buffer with extend=1, then mark the buffer empty; pos += 1 per strobe.
  - After the strobe for byte size-1, wait for the generator to go idle -> EOF.
- PAUSE:
  - Entered from LEADER/STREAM when play=0.
  - No new strobe; the in-flight byte completes; an outstanding fetch completes and the buffer fills.
  - play=1 returns to the prior state; nothing is skipped or repeated.
- EOF:
  - eof=1, busy=0; stays until rewind or reset. play is ignored.
- rewind:
  - Takes effect immediately if mem_rd=0; otherwise deferred to the cycle after mem_ack, with that data discarded.
  - Effect: state IDLE, mem_addr=pos=0, buffer empty, leader counter=LEADER_LEN, eof=0.
  - The in-flight flag is kept until the generator reports done; no strobe is issued while it is set.
- Simultaneous mem_ack and issue: the buffer cannot both fill and drain in one cycle; the issue waits one cycle.
- rewind has priority over play in the same cycle.
- Address arithmetic is unsigned ADDR_W with no wrap; fetching stops at mem_addr == size.

Test Plan:
- LEADER_LEN=3, file_size=2, image {8'hA5,8'h3C}, play=1, generator model done after 20 clks -> strobes carry 55/0, 55/0, 55/0, A5/1, 3C/1; exactly 5 strobes; eof=1 about 20 clks after the last strobe; pos=2.
- Memory ack latency 30 clks, longer than the 20-clk generator time -> every strobe waits for the buffer; no duplicate or skipped byte; mem_rd stays high until ack.
- play drops after the 2nd image strobe of a 4-byte image -> byte 2 completes, no 3rd strobe while paused; play=1 -> byte 3 sent next with pos=2 on resume.
- rewind pulsed while mem_rd=1 -> acted on the cycle after ack; the acked byte is not sent; next play repeats the full leader and starts again from address 0.
- file_size=0, play=1 -> EOF within 2 clks; no mem_rd; no sg_start.
- reset asserted mid-byte (async) -> all outputs at reset values in the same cycle; sg_done=X before the first strobe does not cause a strobe.
